// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers line/frame timing from a VGA sync pair, declares lock
// and emits a qualified pixel stream with active-area coordinates.   Rev 1.0
`default_nettype none

module vga_sync_receiver #(
   parameter int COLOR_WIDTH    = 4,
   parameter int DATA_WIDTH     = 12,
   parameter int CNT_WIDTH      = 11,
   parameter bit SYNC_POL       = 1'b0,
   parameter int H_ACTIVE_START = 144,
   parameter int H_ACTIVE_LEN   = 640,
   parameter int V_ACTIVE_START = 35,
   parameter int V_ACTIVE_LEN   = 480
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   HSync,
   input  logic                   VSync,
   input  logic [COLOR_WIDTH-1:0] Red,
   input  logic [COLOR_WIDTH-1:0] Green,
   input  logic [COLOR_WIDTH-1:0] Blue,
   output logic                   Pixel_valid,
   output logic [DATA_WIDTH-1:0]  Pixel_data,
   output logic [CNT_WIDTH-1:0]   Pixel_x,
   output logic [CNT_WIDTH-1:0]   Pixel_y,
   output logic                   Frame_start,
   output logic                   Locked,
   output logic [CNT_WIDTH-1:0]   H_Total,
   output logic [CNT_WIDTH-1:0]   H_Sync_Len,
   output logic [CNT_WIDTH-1:0]   V_Total,
   output logic                   Timeout
);

   localparam logic [CNT_WIDTH-1:0] c_h_first = CNT_WIDTH'(H_ACTIVE_START);
   localparam logic [CNT_WIDTH-1:0] c_h_last  = CNT_WIDTH'(H_ACTIVE_START + H_ACTIVE_LEN - 1);
   localparam logic [CNT_WIDTH-1:0] c_v_first = CNT_WIDTH'(V_ACTIVE_START);
   localparam logic [CNT_WIDTH-1:0] c_v_last  = CNT_WIDTH'(V_ACTIVE_START + V_ACTIVE_LEN - 1);
   localparam logic [CNT_WIDTH-1:0] c_one     = CNT_WIDTH'(1);

   // Stage 1: sync levels normalised to active-high, plus edge history
   logic                  hs_a_q, vs_a_q, hs_d_q, vs_d_q;
   logic [DATA_WIDTH-1:0] rgb_q;

   logic [CNT_WIDTH-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [CNT_WIDTH-1:0]  h_total_q, h_total_d, h_sync_len_q, h_sync_len_d;
   logic [CNT_WIDTH-1:0]  v_total_q, v_total_d;
   logic                  line_seen_q, line_seen_d, frame_seen_q, frame_seen_d;
   logic                  mismatch_q, mismatch_d, vs_pend_q, vs_pend_d;
   logic                  locked_q, locked_d, timeout_q, timeout_d;

   logic                  valid_q, fs_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CNT_WIDTH-1:0]  x_q, y_q;

   logic                  w_hs_rise, w_hs_fall, w_vs_rise;
   logic                  w_frame_edge, w_line_chk, w_mismatch_now, w_h_sat, w_win;
   logic [CNT_WIDTH-1:0]  w_h_inc, w_v_inc;

   assign w_hs_rise      = hs_a_q & ~hs_d_q;
   assign w_hs_fall      = ~hs_a_q & hs_d_q;
   assign w_vs_rise      = vs_a_q & ~vs_d_q;
   assign w_h_inc        = h_cnt_q + c_one;
   assign w_v_inc        = v_cnt_q + c_one;
   assign w_h_sat        = &h_cnt_q;
   assign w_frame_edge   = w_hs_rise & (vs_pend_q | w_vs_rise);
   assign w_line_chk     = w_hs_rise & line_seen_q;
   assign w_mismatch_now = w_line_chk & (w_h_inc != h_total_q);
   assign w_win          = (h_cnt_q >= c_h_first) && (h_cnt_q <= c_h_last) &&
                           (v_cnt_q >= c_v_first) && (v_cnt_q <= c_v_last);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         hs_a_q <= 1'b0;
         vs_a_q <= 1'b0;
         hs_d_q <= 1'b0;
         vs_d_q <= 1'b0;
         rgb_q  <= '0;
      end else begin
         hs_a_q <= (HSync == SYNC_POL);
         vs_a_q <= (VSync == SYNC_POL);
         hs_d_q <= hs_a_q;
         vs_d_q <= vs_a_q;
         rgb_q  <= {Red, Green, Blue};
      end
   end

   always_comb begin
      h_cnt_d      = h_cnt_q;
      v_cnt_d      = v_cnt_q;
      h_total_d    = h_total_q;
      h_sync_len_d = h_sync_len_q;
      v_total_d    = v_total_q;
      line_seen_d  = line_seen_q;
      frame_seen_d = frame_seen_q;
      mismatch_d   = mismatch_q | w_mismatch_now;
      vs_pend_d    = vs_pend_q;
      locked_d     = locked_q & ~w_mismatch_now;
      timeout_d    = timeout_q;

      if (w_hs_rise) begin
         h_cnt_d     = '0;
         line_seen_d = 1'b1;
         vs_pend_d   = 1'b0;
         timeout_d   = 1'b0;
      end else begin
         if (!w_h_sat)  h_cnt_d   = w_h_inc;
         if (w_vs_rise) vs_pend_d = 1'b1;
      end

      if (w_line_chk) h_total_d    = w_h_inc;
      if (w_hs_fall)  h_sync_len_d = w_h_inc;

      // The line closed by this hs_rise still belongs to the frame being judged
      if (w_frame_edge) begin
         v_total_d    = w_v_inc;
         v_cnt_d      = '0;
         locked_d     = frame_seen_q & ~(mismatch_q | w_mismatch_now) & (w_v_inc == v_total_q);
         frame_seen_d = 1'b1;
         mismatch_d   = 1'b0;
      end else if (w_hs_rise && !(&v_cnt_q)) begin
         v_cnt_d = w_v_inc;
      end

      if (w_h_sat && !w_hs_rise) begin
         timeout_d   = 1'b1;
         locked_d    = 1'b0;
         line_seen_d = 1'b0;
         v_cnt_d     = '0;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         h_total_q    <= '0;
         h_sync_len_q <= '0;
         v_total_q    <= '0;
         line_seen_q  <= 1'b0;
         frame_seen_q <= 1'b0;
         mismatch_q   <= 1'b0;
         vs_pend_q    <= 1'b0;
         locked_q     <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         h_total_q    <= h_total_d;
         h_sync_len_q <= h_sync_len_d;
         v_total_q    <= v_total_d;
         line_seen_q  <= line_seen_d;
         frame_seen_q <= frame_seen_d;
         mismatch_q   <= mismatch_d;
         vs_pend_q    <= vs_pend_d;
         locked_q     <= locked_d;
         timeout_q    <= timeout_d;
      end
   end

   // Stage 2: coordinates and data only move inside the active window
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         valid_q <= 1'b0;
         fs_q    <= 1'b0;
         data_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         valid_q <= locked_q & w_win;
         fs_q    <= locked_q & w_win & (h_cnt_q == c_h_first) & (v_cnt_q == c_v_first);
         if (w_win) begin
            data_q <= rgb_q;
            x_q    <= h_cnt_q - c_h_first;
            y_q    <= v_cnt_q - c_v_first;
         end
      end
   end

   assign Pixel_valid = valid_q;
   assign Pixel_data  = data_q;
   assign Pixel_x     = x_q;
   assign Pixel_y     = y_q;
   assign Frame_start = fs_q;
   assign Locked      = locked_q;
   assign H_Total     = h_total_q;
   assign H_Sync_Len  = h_sync_len_q;
   assign V_Total     = v_total_q;
   assign Timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: directed frames from a small VGA generator, pixel scoreboard.
`timescale 1ns/1ps
`default_nettype none

module tb_vga_sync_receiver;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       HSync = 1'b1;
   logic       VSync = 1'b1;
   logic [3:0] Red = '0, Green = '0, Blue = '0;
   logic       Pixel_valid, Frame_start, Locked, Timeout;
   logic [11:0] Pixel_data;
   logic [7:0] Pixel_x, Pixel_y, H_Total, H_Sync_Len, V_Total;

   vga_sync_receiver #(
      .COLOR_WIDTH(4), .DATA_WIDTH(12), .CNT_WIDTH(8), .SYNC_POL(1'b0),
      .H_ACTIVE_START(2), .H_ACTIVE_LEN(4), .V_ACTIVE_START(1), .V_ACTIVE_LEN(3)
   ) dut (
      .Clk(Clk), .Rst(Rst), .HSync(HSync), .VSync(VSync),
      .Red(Red), .Green(Green), .Blue(Blue),
      .Pixel_valid(Pixel_valid), .Pixel_data(Pixel_data),
      .Pixel_x(Pixel_x), .Pixel_y(Pixel_y), .Frame_start(Frame_start),
      .Locked(Locked), .H_Total(H_Total), .H_Sync_Len(H_Sync_Len),
      .V_Total(V_Total), .Timeout(Timeout)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [11:0] d;
      logic [7:0]  x;
      logic [7:0]  y;
      logic        fs;
   } pix_t;

   pix_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"},   32'(Pixel_valid), 0);
      chk({tag, "_data"},    32'(Pixel_data), 0);
      chk({tag, "_x"},       32'(Pixel_x), 0);
      chk({tag, "_y"},       32'(Pixel_y), 0);
      chk({tag, "_fs"},      32'(Frame_start), 0);
      chk({tag, "_locked"},  32'(Locked), 0);
      chk({tag, "_htotal"},  32'(H_Total), 0);
      chk({tag, "_hsync"},   32'(H_Sync_Len), 0);
      chk({tag, "_vtotal"},  32'(V_Total), 0);
      chk({tag, "_timeout"}, 32'(Timeout), 0);
   endtask

   // vmode: 0 none, 1 VSync from c=5 on, 2 VSync for c<5, 3 VSync whole line (aligned with HSync)
   task automatic drive_line(input int l, input int len, input int vmode, input bit lk,
                             input bit vary, input int rst_c, input int exp_ht);
      logic [11:0] rgb;
      pix_t        p;
      for (int c = 0; c < len; c++) begin
         @(posedge Clk);
         #1;
         HSync = (c < 2) ? 1'b0 : 1'b1;
         case (vmode)
            1:       VSync = (c >= 5) ? 1'b0 : 1'b1;
            2:       VSync = (c < 5)  ? 1'b0 : 1'b1;
            3:       VSync = 1'b0;
            default: VSync = 1'b1;
         endcase
         rgb = vary ? (12'h100 + 12'(l * 16 + c)) : 12'hAFA;
         {Red, Green, Blue} = rgb;
         if (lk && l >= 1 && l <= 3 && c >= 3 && c <= 6) begin
            p.d  = rgb;
            p.x  = 8'(c - 3);
            p.y  = 8'(l - 1);
            p.fs = (c == 3) && (l == 1);
            exp_q.push_back(p);
         end
         if (c == rst_c) begin
            #2 Rst = 1'b1;
            #1 chk_all_zero("midreset");
            exp_q.delete();
            #2 Rst = 1'b0;
         end
         if (c == 5) begin
            @(negedge Clk);
            chk("locked", 32'(Locked), 32'(lk));
            chk("timeout", 32'(Timeout), 0);
            if (exp_ht >= 0) chk("h_total", 32'(H_Total), 32'(exp_ht));
         end
      end
   endtask

   task automatic run_frame(input int first_mode, input int last_mode, input int stretch,
                            input bit lk, input bit vary, input int rst_line, input bit ht_chk);
      int vm, ht, ln;
      bit ll;
      for (int l = 0; l < 12; l++) begin
         vm = (l == 0) ? first_mode : ((l == 11) ? last_mode : 0);
         ll = lk && !(stretch >= 0 && l > stretch) && !(rst_line >= 0 && l >= rst_line);
         ht = !ht_chk ? -1 : ((stretch >= 0 && l == stretch + 1) ? 11 : 10);
         ln = (l == stretch) ? 11 : 10;
         drive_line(l, ln, vm, ll, vary, (l == rst_line) ? 4 : -1, ht);
      end
   endtask

   always @(negedge Clk) begin
      pix_t e;
      if (!Rst) begin
         if (Pixel_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'(Pixel_valid), 0);
            end else begin
               e = exp_q.pop_front();
               chk("pix_data", 32'(Pixel_data), 32'(e.d));
               chk("pix_x", 32'(Pixel_x), 32'(e.x));
               chk("pix_y", 32'(Pixel_y), 32'(e.y));
               chk("frame_start", 32'(Frame_start), 32'(e.fs));
            end
         end else begin
            chk("frame_start_idle", 32'(Frame_start), 0);
         end
      end
   end

   initial begin
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk_all_zero("reset");
      @(posedge Clk);
      #1 Rst = 1'b0;

      // Acquisition: lock expected from the third frame boundary
      run_frame(3, 1, -1, 1'b0, 1'b0, -1, 1'b0);
      chk("h_total_meas", 32'(H_Total), 10);
      chk("h_sync_len", 32'(H_Sync_Len), 2);
      run_frame(2, 1, -1, 1'b0, 1'b0, -1, 1'b1);
      chk("v_total_meas", 32'(V_Total), 12);
      run_frame(2, 1, -1, 1'b1, 1'b0, -1, 1'b1);

      // Per-clock varying colour exposes pin-to-output latency
      run_frame(2, 1, -1, 1'b1, 1'b1, -1, 1'b1);
      chk("hold_data", 32'(Pixel_data), 32'h136);
      chk("hold_x", 32'(Pixel_x), 3);
      chk("hold_y", 32'(Pixel_y), 2);

      // Stretched line 2 drops lock; one clean frame later it returns
      run_frame(2, 1, 2, 1'b1, 1'b0, -1, 1'b1);
      run_frame(2, 1, -1, 1'b0, 1'b0, -1, 1'b1);
      run_frame(2, 1, -1, 1'b1, 1'b0, -1, 1'b1);
      run_frame(2, 0, -1, 1'b1, 1'b0, -1, 1'b1);

      // VSync edge coincident with HSync edge
      run_frame(3, 0, -1, 1'b1, 1'b0, -1, 1'b1);
      chk("v_total_aligned", 32'(V_Total), 12);

      // HSync loss
      for (int k = 0; k < 300; k++) begin
         @(posedge Clk);
         #1;
         HSync = 1'b1;
         VSync = 1'b1;
         if (k == 200 || k == 299) begin
            @(negedge Clk);
            chk("timeout_hold", 32'(Timeout), (k == 299) ? 1 : 0);
            chk("locked_hold", 32'(Locked), (k == 299) ? 0 : 1);
         end
      end
      run_frame(0, 1, -1, 1'b0, 1'b0, -1, 1'b1);

      // Asynchronous reset mid-line, then a fresh three-boundary acquisition
      run_frame(2, 1, -1, 1'b0, 1'b0, 6, 1'b0);
      run_frame(2, 1, -1, 1'b0, 1'b0, -1, 1'b1);
      run_frame(2, 1, -1, 1'b0, 1'b0, -1, 1'b1);
      run_frame(2, 1, -1, 1'b1, 1'b0, -1, 1'b1);

      repeat (5) @(posedge Clk);
      @(negedge Clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
